// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for N requesters with registered one-hot grants, a dead
// cycle between owners, MAX_HOLD preemption and a lock that suppresses it.
//
// state   | meaning
// IDLE    | no owner; grant is zero; next edge grants the round-robin winner
// GRANTED | one owner holds the grant until it releases or is preempted
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [N-1:0]                  req_i,
  input  logic                          lock_i,
  output logic [N-1:0]                  grant_o,
  output logic                          grant_valid_o,
  output logic [$clog2(N)-1:0]          grant_id_o,
  output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt_o,
  output logic                          preempted_o
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            pre_q, pre_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic            others_req;

  // Search starts one past the last owner so every requester gets its turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N;
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign others_req = |(req_i & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        hold_d  = '0;
        if (win_found) begin
          grant_d[win_id] = 1'b1;
          id_d    = win_id;
          hold_d  = HW'(1);
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (!req_i[id_q]) begin
          grant_d = '0;
          last_d  = id_q;
          hold_d  = '0;
          state_d = IDLE;
        end else if (hold_q == HW'(MAX_HOLD) && !lock_i && others_req) begin
          grant_d = '0;
          last_d  = id_q;
          hold_d  = '0;
          pre_d   = 1'b1;
          state_d = IDLE;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= IDW'(N - 1);
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= |grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_id_o    = id_q;
  assign hold_cnt_o    = hold_q;
  assign preempted_o   = pre_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic, all
// checked against an owner/pointer reference model updated once per edge.
module tb_rr_grant_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = $clog2(N);
  localparam int HW       = $clog2(MAX_HOLD + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic           lock;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [HW-1:0]  hold_cnt;
  logic           preempted;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int m_owner;   // -1 when nobody holds the grant
  int m_last;
  int m_id;
  int m_held;
  int m_pre;

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .req_i        (req),
    .lock_i       (lock),
    .grant_o      (grant),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id),
    .hold_cnt_o   (hold_cnt),
    .preempted_o  (preempted)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic l, input logic rs);
    int others;
    if (rs) begin
      m_owner = -1; m_last = N - 1; m_id = 0; m_held = 0; m_pre = 0;
    end else if (m_owner < 0) begin
      m_pre = 0;
      if (r != 0) begin
        m_owner = rr_pick(r, m_last);
        m_id    = m_owner;
        m_held  = 1;
      end
    end else begin
      others = ((int'(r) & ~(1 << m_owner)) != 0) ? 1 : 0;
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_held = 0; m_pre = 0;
      end else if (m_held == MAX_HOLD && !l && others == 1) begin
        m_last = m_owner; m_owner = -1; m_held = 0; m_pre = 1;
      end else begin
        m_held = (m_held + 1 > MAX_HOLD) ? MAX_HOLD : m_held + 1;
        m_pre  = 0;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_grant;
    exp_grant = (m_owner < 0) ? 0 : (1 << m_owner);
    check("grant", int'(grant), exp_grant);
    check("grant_valid", int'(grant_valid), (m_owner < 0) ? 0 : 1);
    check("grant_id", int'(grant_id), m_id);
    check("hold_cnt", int'(hold_cnt), m_held);
    check("preempted", int'(preempted), m_pre);
    check("onehot0", int'($onehot0(grant)), 1);
    check("valid_eq_or", int'(grant_valid), int'(|grant));
  endtask

  task automatic step(input logic [N-1:0] r, input logic l, input logic rs);
    req = r; lock = l; rst = rs;
    @(posedge clk);
    model_edge(r, l, rs);
    #1;
    check_all();
  endtask

  int pre_seq [14] = '{1,1,1,1,0,2,2,2,2,0,1,1,1,1};
  int pre_flag[14] = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0};
  logic [N-1:0] rq;

  initial begin
    req = '0; lock = 1'b0; rst = 1'b1;
    m_owner = -1; m_last = N - 1; m_id = 0; m_held = 0; m_pre = 0;

    // reset held with all requesting, then first grant to requester 0
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    check("reset_grant", int'(grant), 0);
    step(4'b1111, 1'b0, 1'b0);
    check("first_grant", int'(grant), 1);
    check("first_id", int'(grant_id), 0);

    // sole requester never preempted
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      check("sole_grant", int'(grant), 4);
      check("sole_hold", int'(hold_cnt), (i + 1 > MAX_HOLD) ? MAX_HOLD : i + 1);
    end

    // preemption rotation between 0 and 1
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step(4'b0011, 1'b0, 1'b0);
      check("rot_grant", int'(grant), pre_seq[i]);
      check("rot_pre", int'(preempted), pre_flag[i]);
    end

    // lock holds past MAX_HOLD, release one edge after lock falls
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0011, 1'b1, 1'b0);
    check("lock_grant", int'(grant), 1);
    check("lock_hold", int'(hold_cnt), MAX_HOLD);
    step(4'b0011, 1'b0, 1'b0);
    check("unlock_gap", int'(grant), 0);
    step(4'b0011, 1'b0, 1'b0);
    check("unlock_next", int'(grant), 2);

    // early release and pointer advance
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1011, 1'b0, 1'b0);
    step(4'b1011, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    check("early_gap", int'(grant), 0);
    step(4'b1011, 1'b0, 1'b0);
    check("early_next", int'(grant), 2);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    check("ptr_next", int'(grant), 8);

    // reset mid-grant restores pointer to N-1
    step(4'b1010, 1'b0, 1'b1);
    check("midrst_gap", int'(grant), 0);
    step(4'b1010, 1'b0, 1'b0);
    check("midrst_next", int'(grant), 2);

    // random traffic with sticky requests
    rq = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = rq ^ N'($urandom_range(0, (1 << N) - 1));
      step(rq, ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters, extending the team's two-requester grant FSM to N ports.
- Adds fairness rotation, a maximum-hold preemption limit, and a lock input that suppresses preemption.
- Sits between requesting blocks and the shared resource. Grants are registered, one-hot, and separated by a mandatory one-cycle dead gap.

Parameters:
- N, 4, number of requesters (>=2).
- MAX_HOLD, 8, cycles an owner may hold the grant while others request (>=1).

Ports:
- clock  input  1  single system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector, bit i = requester i; level-sensitive, held until done.
- lock  input  1  owner asks to keep the grant past MAX_HOLD; meaningful only while grant_valid=1.
- grant  output  N  one-hot grant (registered), all-zero when no owner.
- grant_valid  output  1  equals |grant (registered).
- grant_id  output  clog2(N)  index of current owner; holds the last owner when grant_valid=0.
- hold_cnt  output  clog2(MAX_HOLD+1)  cycles the current grant has been asserted, saturating at MAX_HOLD.
- preempted  output  1  one-cycle pulse in the dead cycle following a MAX_HOLD preemption.

Behaviour:
- Reset is sampled on posedge clock while reset=1 and overrides everything. It sets:
  - state=IDLE, grant=0, grant_valid=0, grant_id=0
  - hold_cnt=0, preempted=0
  - last pointer = N-1, so requester 0 has top priority first.
- Reset asserted mid-grant: grant drops on that edge, with no dead-cycle bookkeeping.
- Winner selection: the first index i in order last+1, last+2, ... (mod N) with req[i]=1. It is purely combinational from req and the last pointer.
- Two states only: IDLE and GRANTED. All outputs are registered.
- IDLE:
  - If req==0: stay IDLE, outputs unchanged at zero, preempted=0.
  - If req!=0: on the edge, grant<=onehot(winner), grant_id<=winner, hold_cnt<=1, state<=GRANTED.
  - Latency: req sampled at edge k gives grant visible after edge k, i.e. one cycle.
- GRANTED, evaluated on each edge in priority order:
  1. req[grant_id]==0 (owner released): grant<=0, last<=grant_id, hold_cnt<=0, state<=IDLE, preempted<=0.
  2. hold_cnt==MAX_HOLD, lock==0, and any other req bit set: grant<=0, last<=grant_id, hold_cnt<=0, state<=IDLE, preempted<=1.
  3. Otherwise keep the grant; hold_cnt<=min(hold_cnt+1, MAX_HOLD).
- Consequences of these rules:
  - An owner competing with others holds the grant for exactly MAX_HOLD cycles.
  - With lock=1 the grant persists indefinitely and hold_cnt saturates. When lock falls with others requesting, release happens on the next edge.
- Dead gap: every grant change passes through at least one cycle of grant=0. Back-to-back grants to different owners are therefore never adjacent.
- Re-grant to the same requester:
  - Allowed after the gap only if it is the round-robin winner.
  - Example: the released owner is the sole requester, so it wins again after one zero cycle.
- Simultaneous events:
  - Owner drop and preemption in the same cycle: the drop wins, preempted=0.
  - Requests that arrive while GRANTED do not affect the grant until a release.
- preempted is high only in the single IDLE cycle after a rule-2 release, then returns to 0.
- Invariant checked by assertion: $onehot0(grant) always holds, and grant_valid==|grant.

Test Plan:
- Reset with N=4, MAX_HOLD=4: hold reset=1 two cycles with req=4'b1111 -> grant=0, grant_valid=0. Deassert reset -> grant=4'b0001, grant_id=0 one cycle later.
- Sole requester: req=4'b0100 held 10 cycles -> grant=4'b0100 continuous from cycle 1, hold_cnt 1,2,3,4,4,..., no preemption, preempted=0 throughout.
- Preemption rotation: req=4'b0011 steady, lock=0 -> grant sequence 0001 x4, 0000 (preempted=1), 0010 x4, 0000 (preempted=1), 0001 x4.
- Lock: req=4'b0011, lock=1 from the first grant -> grant=0001 held 10 cycles with hold_cnt=4. Drop lock at cycle 10 -> grant=0000 next cycle, then 0010.
- Early release and pointer: req=4'b1011, owner 0 drops req after 2 granted cycles -> one zero cycle, then grant=0010. Next release -> 1000, not 0001.
- Reset mid-grant: while grant=4'b1000, pulse reset one cycle with req=4'b1010 -> grant=0 after the reset edge, then grant=4'b0010, because the pointer was reset to N-1.
